// File: rtl/apb_decoder_tmo.sv
// APB address decoder with per-transfer wait timeout.
// One upstream APB port fans out to NUM_SLAVES downstream ports selected by
// in_paddr[31:SEL_LSB]. Unmapped regions are answered locally with an error,
// and a stalled slave is aborted after TIMEOUT wait cycles.
//
// state | meaning
// IDLE  | no transfer latched; setup decoded combinationally
// FWD   | transfer forwarded to the latched slave, waiting for pready
// DERR  | unmapped address, local zero-wait error response
// TMO   | one-cycle abort response after a slave timeout
module apb_decoder_tmo #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 28,
  parameter int SLOT_BASE  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    in_psel,
  input  logic                    in_penable,
  input  logic                    in_pwrite,
  input  logic [31:0]             in_paddr,
  input  logic [31:0]             in_pwdata,
  output logic [31:0]             in_prdata,
  output logic                    in_pready,
  output logic                    in_pslverr,
  output logic [NUM_SLAVES-1:0]   out_psel,
  output logic [NUM_SLAVES-1:0]   out_penable,
  output logic [31:0]             out_paddr,
  output logic [31:0]             out_pwdata,
  output logic                    out_pwrite,
  input  logic [32*NUM_SLAVES-1:0] out_prdata,
  input  logic [NUM_SLAVES-1:0]   out_pready,
  input  logic [NUM_SLAVES-1:0]   out_pslverr,
  input  logic                    err_clr,
  output logic [7:0]              err_count,
  output logic                    tmo_flag
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, FWD, DERR, TMO} state_t;

  state_t                state, next_state;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         hit_idx;
  logic [NUM_SLAVES-1:0] hit;
  logic                  mapped;
  logic [31:0]           region;
  logic [CW-1:0]         wait_cnt;
  logic                  sel_ready, sel_err;
  logic [31:0]           sel_rdata;
  logic                  abort;
  logic                  setup;
  logic                  err_inc;

  assign out_paddr  = in_paddr;
  assign out_pwdata = in_pwdata;
  assign out_pwrite = in_pwrite;

  assign region = in_paddr >> SEL_LSB;
  assign setup  = in_psel && !in_penable;

  // Region decode: one-hot hit vector plus its encoded index.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    mapped  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (region == 32'(SLOT_BASE + i)) begin
        hit[i]  = 1'b1;
        hit_idx = IW'(i);
        mapped  = 1'b1;
      end
    end
  end

  // Response mux from the latched slave (a true mux, so idle slaves cannot leak).
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IW'(i)) begin
        sel_ready = out_pready[i];
        sel_err   = out_pslverr[i];
        sel_rdata = out_prdata[i*32 +: 32];
      end
    end
  end

  assign abort = (TIMEOUT > 0) && in_penable && !sel_ready && (wait_cnt == CW'(TIMEOUT));

  // State register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (setup) next_state = mapped ? FWD : DERR;
      FWD: begin
        if (!in_psel)                      next_state = IDLE;
        else if (in_penable && sel_ready)  next_state = IDLE;
        else if (abort)                    next_state = TMO;
      end
      DERR: if (!in_psel || in_penable) next_state = IDLE;
      TMO:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic; everything facing either bus is held low during reset.
  always_comb begin
    out_psel    = '0;
    out_penable = '0;
    in_pready   = 1'b0;
    in_pslverr  = 1'b0;
    in_prdata   = '0;
    if (!preset) begin
      case (state)
        IDLE: out_psel = {NUM_SLAVES{in_psel}} & hit;
        FWD: begin
          for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == IW'(i)) begin
              out_psel[i]    = in_psel;
              out_penable[i] = in_penable;
            end
          end
          in_pready  = sel_ready;
          in_pslverr = sel_err;
          in_prdata  = sel_rdata;
        end
        DERR: begin
          in_pready  = in_penable;
          in_pslverr = in_penable;
        end
        TMO: begin
          in_pready  = 1'b1;
          in_pslverr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Latch the decoded slave index on each setup cycle.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                     idx <= '0;
    else if (state == IDLE && setup) idx <= hit_idx;
  end

  // Wait counter: zero outside FWD, counts stalled access cycles while staying in FWD.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)
      wait_cnt <= '0;
    else if (state == FWD && next_state == FWD) begin
      if (TIMEOUT > 0 && in_penable && !sel_ready && wait_cnt != CW'(TIMEOUT))
        wait_cnt <= wait_cnt + CW'(1);
    end else
      wait_cnt <= '0;
  end

  assign err_inc = (state == FWD  && in_psel && in_penable && sel_ready && sel_err) ||
                   (state == DERR && in_psel && in_penable) ||
                   (state == TMO);

  // Saturating error counter and sticky timeout flag; clear wins.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      err_count <= '0;
      tmo_flag  <= 1'b0;
    end else if (err_clr) begin
      err_count <= '0;
      tmo_flag  <= 1'b0;
    end else begin
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (state == FWD && next_state == TMO) tmo_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_decoder_tmo.sv
// Directed bench for apb_decoder_tmo with default parameters.
module tb_apb_decoder_tmo;

  logic         pclk = 1'b0;
  logic         preset;
  logic         in_psel, in_penable, in_pwrite;
  logic [31:0]  in_paddr, in_pwdata;
  logic [31:0]  in_prdata;
  logic         in_pready, in_pslverr;
  logic [3:0]   out_psel, out_penable;
  logic [31:0]  out_paddr, out_pwdata;
  logic         out_pwrite;
  logic [127:0] out_prdata;
  logic [3:0]   out_pready, out_pslverr;
  logic         err_clr;
  logic [7:0]   err_count;
  logic         tmo_flag;

  int checks = 0;
  int errors = 0;

  apb_decoder_tmo dut (
    .pclk(pclk), .preset(preset),
    .in_psel(in_psel), .in_penable(in_penable), .in_pwrite(in_pwrite),
    .in_paddr(in_paddr), .in_pwdata(in_pwdata),
    .in_prdata(in_prdata), .in_pready(in_pready), .in_pslverr(in_pslverr),
    .out_psel(out_psel), .out_penable(out_penable),
    .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_pwrite(out_pwrite),
    .out_prdata(out_prdata), .out_pready(out_pready), .out_pslverr(out_pslverr),
    .err_clr(err_clr), .err_count(err_count), .tmo_flag(tmo_flag)
  );

  always #5 pclk = ~pclk;

  task automatic do_setup(input logic [31:0] addr, input logic wr, input logic [31:0] data);
    @(negedge pclk);
    in_psel = 1'b1; in_penable = 1'b0; in_pwrite = wr; in_paddr = addr; in_pwdata = data;
    #1;
  endtask

  task automatic do_access();
    @(negedge pclk);
    in_penable = 1'b1;
    #1;
  endtask

  task automatic do_idle();
    @(negedge pclk);
    in_psel = 1'b0; in_penable = 1'b0; out_pready = '0; out_pslverr = '0; err_clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b0;
    in_paddr = 32'h4000_0000; in_pwdata = '0;
    out_prdata = {4{32'hDEAD_BEEF}}; out_pready = 4'hF; out_pslverr = 4'hF; err_clr = 1'b0;
    repeat (2) @(negedge pclk);
    #1;
    checks++; if (out_psel !== 4'b0000) begin errors++; $display("FAIL rst_psel got %b exp 0000", out_psel); end
    checks++; if (in_pready !== 1'b0) begin errors++; $display("FAIL rst_pready got %b exp 0", in_pready); end
    checks++; if (in_prdata !== 32'h0) begin errors++; $display("FAIL rst_prdata got %h exp 0", in_prdata); end
    checks++; if (err_count !== 8'd0 || tmo_flag !== 1'b0) begin errors++; $display("FAIL rst_status got %0d/%b exp 0/0", err_count, tmo_flag); end
    @(negedge pclk);
    preset = 1'b0; in_psel = 1'b0; out_pready = '0; out_pslverr = '0; out_prdata = '0;
  endtask

  task automatic test_write_wait();
    do_setup(32'h5000_0010, 1'b1, 32'hA5A5_A5A5);
    checks++; if (out_psel !== 4'b0010 || out_penable !== 4'b0000) begin errors++; $display("FAIL wr_setup_sel got %b/%b exp 0010/0000", out_psel, out_penable); end
    do_access();
    checks++; if (out_penable !== 4'b0010 || out_pwdata !== 32'hA5A5_A5A5 || out_pwrite !== 1'b1) begin errors++; $display("FAIL wr_access got %b %h %b exp 0010 a5a5a5a5 1", out_penable, out_pwdata, out_pwrite); end
    checks++; if (in_pready !== 1'b0) begin errors++; $display("FAIL wr_wait1 got %b exp 0", in_pready); end
    do_access();
    checks++; if (in_pready !== 1'b0 || out_psel !== 4'b0010) begin errors++; $display("FAIL wr_wait2 got %b/%b exp 0/0010", in_pready, out_psel); end
    @(negedge pclk); out_pready = 4'b0010; #1;
    checks++; if (in_pready !== 1'b1 || in_pslverr !== 1'b0) begin errors++; $display("FAIL wr_done got %b/%b exp 1/0", in_pready, in_pslverr); end
    do_idle();
    checks++; if (err_count !== 8'd0 || out_psel !== 4'b0000) begin errors++; $display("FAIL wr_after got %0d/%b exp 0/0000", err_count, out_psel); end
  endtask

  task automatic test_read_mux();
    out_prdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
    out_pslverr = 4'b1110;
    do_setup(32'h4000_0000, 1'b0, 32'h0);
    checks++; if (out_psel !== 4'b0001 || in_prdata !== 32'h0) begin errors++; $display("FAIL rd_setup got %b/%h exp 0001/0", out_psel, in_prdata); end
    out_pready = 4'b1111;
    do_access();
    checks++; if (in_prdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h exp 12345678", in_prdata); end
    checks++; if (in_pready !== 1'b1 || in_pslverr !== 1'b0) begin errors++; $display("FAIL rd_resp got %b/%b exp 1/0", in_pready, in_pslverr); end
    do_idle();
    checks++; if (in_prdata !== 32'h0) begin errors++; $display("FAIL rd_idle_data got %h exp 0", in_prdata); end
  endtask

  task automatic test_back_to_back();
    out_prdata = {32'hCAFE_0003, 32'h0, 32'h0, 32'hBEEF_0000};
    out_pready = 4'b1111;
    do_setup(32'h4000_0004, 1'b0, 32'h0);
    do_access();
    checks++; if (in_prdata !== 32'hBEEF_0000 || in_pready !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp beef0000/1", in_prdata, in_pready); end
    do_setup(32'h7000_0008, 1'b0, 32'h0);
    checks++; if (out_psel !== 4'b1000 || out_penable !== 4'b0000 || in_pready !== 1'b0) begin errors++; $display("FAIL b2b_setup got %b/%b/%b exp 1000/0000/0", out_psel, out_penable, in_pready); end
    do_access();
    checks++; if (out_penable !== 4'b1000 || in_prdata !== 32'hCAFE_0003) begin errors++; $display("FAIL b2b_second got %b/%h exp 1000/cafe0003", out_penable, in_prdata); end
    do_idle();
    out_prdata = '0;
  endtask

  task automatic test_unmapped();
    do_setup(32'h9000_0000, 1'b0, 32'h0);
    checks++; if (out_psel !== 4'b0000 || in_pready !== 1'b0) begin errors++; $display("FAIL um_setup got %b/%b exp 0000/0", out_psel, in_pready); end
    do_access();
    checks++; if (out_psel !== 4'b0000 || in_pready !== 1'b1 || in_pslverr !== 1'b1) begin errors++; $display("FAIL um_access got %b/%b/%b exp 0000/1/1", out_psel, in_pready, in_pslverr); end
    do_idle();
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL um_count got %0d exp 1", err_count); end
  endtask

  task automatic test_timeout();
    do_setup(32'h6000_0000, 1'b0, 32'h0);
    for (int k = 0; k < 256; k++) begin
      do_access();
      if (k == 254 || k == 255) begin
        checks++; if (out_psel !== 4'b0100 || out_penable !== 4'b0100 || in_pready !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d got %b/%b/%b exp 0100/0100/0", k, out_psel, out_penable, in_pready); end
      end
    end
    @(negedge pclk); #1;
    checks++; if (out_psel !== 4'b0000 || out_penable !== 4'b0000) begin errors++; $display("FAIL tmo_drop got %b/%b exp 0000/0000", out_psel, out_penable); end
    checks++; if (in_pready !== 1'b1 || in_pslverr !== 1'b1 || in_prdata !== 32'h0) begin errors++; $display("FAIL tmo_resp got %b/%b/%h exp 1/1/0", in_pready, in_pslverr, in_prdata); end
    checks++; if (tmo_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b exp 1", tmo_flag); end
    do_idle();
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL tmo_count got %0d exp 2", err_count); end
    // Rerun: slave answers exactly when the counter sits at TIMEOUT.
    do_setup(32'h6000_0000, 1'b0, 32'h0);
    for (int k = 0; k < 256; k++) begin
      @(negedge pclk);
      in_penable = 1'b1;
      if (k == 255) out_pready = 4'b0100;
      #1;
    end
    checks++; if (in_pready !== 1'b1 || in_pslverr !== 1'b0 || out_psel !== 4'b0100) begin errors++; $display("FAIL tmo_edge got %b/%b/%b exp 1/0/0100", in_pready, in_pslverr, out_psel); end
    do_idle();
    checks++; if (err_count !== 8'd2 || tmo_flag !== 1'b1) begin errors++; $display("FAIL tmo_edge_status got %0d/%b exp 2/1", err_count, tmo_flag); end
  endtask

  task automatic test_protocol_drop();
    do_setup(32'h5000_0000, 1'b0, 32'h0);
    do_access();
    do_access();
    @(negedge pclk); in_psel = 1'b0; in_penable = 1'b0; #1;
    checks++; if (out_psel !== 4'b0000 || in_pready !== 1'b0) begin errors++; $display("FAIL drop_sel got %b/%b exp 0000/0", out_psel, in_pready); end
    out_pready = 4'b0001;
    do_setup(32'h4000_0000, 1'b0, 32'h0);
    checks++; if (out_psel !== 4'b0001) begin errors++; $display("FAIL drop_next_setup got %b exp 0001", out_psel); end
    do_access();
    checks++; if (in_pready !== 1'b1 || in_pslverr !== 1'b0) begin errors++; $display("FAIL drop_next_done got %b/%b exp 1/0", in_pready, in_pslverr); end
    do_idle();
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL drop_count got %0d exp 2", err_count); end
  endtask

  task automatic test_saturate();
    logic [31:0] bad_addr [3];
    bad_addr[0] = 32'h9000_0000; bad_addr[1] = 32'h3000_0000; bad_addr[2] = 32'hF000_0000;
    for (int n = 0; n < 256; n++) begin
      do_setup(bad_addr[n % 3], 1'b0, 32'h0);
      do_access();
      if (n == 10) begin
        checks++; if (err_count !== 8'd12) begin errors++; $display("FAIL sat_partial got %0d exp 12", err_count); end
      end
    end
    do_idle();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", err_count); end
    do_setup(32'h9000_0000, 1'b0, 32'h0);
    @(negedge pclk); in_penable = 1'b1; err_clr = 1'b1; #1;
    do_idle();
    checks++; if (err_count !== 8'd0 || tmo_flag !== 1'b0) begin errors++; $display("FAIL clr_prio got %0d/%b exp 0/0", err_count, tmo_flag); end
    out_pready = 4'b1000; out_pslverr = 4'b1000;
    do_setup(32'h7000_0000, 1'b1, 32'h1);
    do_access();
    checks++; if (in_pslverr !== 1'b1 || in_pready !== 1'b1) begin errors++; $display("FAIL slverr_resp got %b/%b exp 1/1", in_pslverr, in_pready); end
    do_idle();
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL slverr_count got %0d exp 1", err_count); end
  endtask

  task automatic test_reset_mid();
    out_prdata = {32'h0, 32'h0, 32'h5555_AAAA, 32'h0F0F_0F0F};
    do_setup(32'h5000_0000, 1'b0, 32'h0);
    do_access();
    checks++; if (out_psel !== 4'b0010 || out_penable !== 4'b0010) begin errors++; $display("FAIL rmid_pre got %b/%b exp 0010/0010", out_psel, out_penable); end
    #1; preset = 1'b1; out_pready = 4'b0010; #1;
    checks++; if (out_psel !== 4'b0000 || out_penable !== 4'b0000 || in_pready !== 1'b0 || in_prdata !== 32'h0) begin errors++; $display("FAIL rmid_async got %b/%b/%b/%h exp 0000/0000/0/0", out_psel, out_penable, in_pready, in_prdata); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", err_count); end
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    do_idle();
    out_pready = 4'b0001;
    do_setup(32'h4000_0000, 1'b0, 32'h0);
    do_access();
    checks++; if (in_pready !== 1'b1 || in_prdata !== 32'h0F0F_0F0F || in_pslverr !== 1'b0) begin errors++; $display("FAIL rmid_resume got %b/%h/%b exp 1/0f0f0f0f/0", in_pready, in_prdata, in_pslverr); end
    do_idle();
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rmid_after got %0d exp 0", err_count); end
  endtask

  initial begin
    test_reset();
    test_write_wait();
    test_read_mux();
    test_back_to_back();
    test_unmapped();
    test_timeout();
    test_protocol_drop();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
